add_round_key_stage: RTL and testbench
======================================

// Module: add_round_key_stage
// PURPOSE
//   Registered AddRoundKey stage sitting directly downstream of MixColumns in the iterative AES-128 datapath.
//   Holds a local table of NR+1 round keys (written by the key-expansion block), XORs each accepted 128-bit state with the key for
//   the current round, and presents the result on a valid/ready output. An internal round counter tracks the round of each beat
//   and flags the last round. Key-table writes are blocked while a block is mid-flight.
// PARAMETERS
//   NR   10   number of AES rounds; the key table holds NR+1 entries (0..NR)
//   DW   128  state/key width in bits; only 128 is supported
// PORTS
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous, active-low reset
//   key_we     in   1    round-key table write strobe
//   key_waddr  in   4    round-key index 0..NR
//   key_wdata  in   DW   round-key value, byte order identical to the state ([127:120] = byte 0)
//   key_busy   out  1    high while a block is in progress (round counter != 0)
//   key_err    out  1    sticky: a write was attempted while busy, or with key_waddr > NR
//   in_valid   in   1    input state valid (state from MixColumns, or plaintext for round 0)
//   in_ready   out  1    stage can accept a beat
//   in_data    in   DW   input state
//   out_valid  out  1    output beat valid
//   out_ready  in   1    downstream accepts the beat
//   out_data   out  DW   in_data XOR key[round]
//   out_round  out  4    round index applied to out_data
//   out_last   out  1    out_round == NR
// BEHAVIOUR
//   Reset (async, rst_n=0): out_valid=0, out_data=0, out_round=0, out_last=0, key_err=0, round counter=0 (key_busy=0).
//     The key table is not reset; its contents are undefined until written.
//   Handshake:
//     - in_ready = !out_valid || out_ready (combinational).
//     - A beat is accepted when in_valid && in_ready; a beat is delivered when out_valid && out_ready.
//     - out_data, out_round and out_last are held stable while out_valid && !out_ready.
//     - Latency is 1 cycle: data accepted at edge N is valid after edge N.
//     - Full throughput (one beat per cycle) when out_ready is held high.
//   On accept:
//     - out_data <= in_data ^ key[rcnt]; out_round <= rcnt; out_last <= (rcnt == NR); out_valid <= 1.
//     - rcnt <= (rcnt == NR) ? 0 : rcnt + 1. The wrap from NR to 0 ends the block.
//   No accept:
//     - If out_ready is high, out_valid <= 0; otherwise out_valid holds.
//     - rcnt is unchanged.
//   Key table writes:
//     - A write is performed at the clock edge when key_we && !key_busy && key_waddr <= NR.
//     - key_busy is rcnt != 0, so writes are allowed between blocks only.
//     - Otherwise the write is dropped and key_err <= 1. key_err clears only on reset.
//   Write and accept on the same edge, with rcnt == 0 and key_waddr == 0:
//     - The XOR uses the OLD key[0]; the new value applies from the next block.
//   Reset mid-block (rcnt != 0): rcnt returns to 0 and the in-flight output is discarded; the key table is retained.
//   Width: plain bitwise XOR over DW bits; rcnt is 4 bits and never exceeds NR.
// TESTING
//   1. Load FIPS-197 App.B keys; key[0]=2b7e151628aed2a6abf7158809cf4f3c, in 3243f6a8885a308d313198a2e0370734
//      -> out 193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, out_last=0.
//   2. Stream 11 beats with out_ready=1: one output per cycle, out_round 0..10, out_last only on the 11th beat,
//      key_busy falls after the 11th accept.
//   3. Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_data/out_round stable, in_ready=0,
//      no beat lost or duplicated.
//   4. Write key_waddr=3 while key_busy=1 -> table unchanged (round 3 output still uses the old key), key_err=1 and stays 1.
//   5. Write key_waddr=11 -> dropped, key_err=1; write key_waddr=10 while idle -> accepted, key_err unchanged.
//   6. Assert rst_n=0 after 4 beats -> out_valid=0 immediately; the next block starts at out_round=0 with the old keys.

Source files
------------

// File: rtl/add_round_key_stage.sv
// AddRoundKey stage for the iterative AES-128 datapath.
// Holds NR+1 round keys and XORs each accepted state with the key for the current round.
// The result sits in a one-deep valid/ready output register.
module add_round_key_stage #(
  parameter int NR = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_we,
  input  logic [3:0]    key_waddr,
  input  logic [DW-1:0] key_wdata,
  output logic          key_busy,
  output logic          key_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [3:0]    out_round,
  output logic          out_last
);

  localparam logic [3:0] NR_L = 4'(NR);

  // Round-key table. It is deliberately left out of reset so the keys survive a mid-block reset.
  logic [DW-1:0] key_mem [0:NR];

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic [3:0]    out_round_q, out_round_d;
  logic          out_last_q,  out_last_d;
  logic [3:0]    rcnt_q,      rcnt_d;
  logic          key_err_q,   key_err_d;

  logic accept;
  logic key_wr_ok;

  // Handshake, round sequencing and key-write gating.
  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    accept      = in_valid && in_ready;
    key_busy    = (rcnt_q != 4'd0);
    key_wr_ok   = key_we && !key_busy && (key_waddr <= NR_L);
    key_err_d   = key_err_q || (key_we && !key_wr_ok);

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_round_d = out_round_q;
    out_last_d  = out_last_q;
    rcnt_d      = rcnt_q;

    if (accept) begin
      // The table is read before any same-edge write lands, so the old key applies.
      out_data_d  = in_data ^ key_mem[rcnt_q];
      out_round_d = rcnt_q;
      out_last_d  = (rcnt_q == NR_L);
      out_valid_d = 1'b1;
      rcnt_d      = (rcnt_q == NR_L) ? 4'd0 : rcnt_q + 4'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register, round counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_round_q <= 4'd0;
      out_last_q  <= 1'b0;
      rcnt_q      <= 4'd0;
      key_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_round_q <= out_round_d;
      out_last_q  <= out_last_d;
      rcnt_q      <= rcnt_d;
      key_err_q   <= key_err_d;
    end
  end

  // Key table write port; only allowed between blocks and for valid indices.
  always_ff @(posedge clk) begin
    if (key_wr_ok) begin
      key_mem[key_waddr] <= key_wdata;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_round = out_round_q;
  assign out_last  = out_last_q;
  assign key_err   = key_err_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Scoreboard bench for add_round_key_stage: a negedge monitor keeps a behavioural model
// (key table, block position, sticky error) and checks every output beat and status flag.
module tb_add_round_key_stage;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_we;
  logic [3:0]   key_waddr;
  logic [127:0] key_wdata;
  logic         key_busy;
  logic         key_err;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_round;
  logic         out_last;

  add_round_key_stage #(.NR(NR), .DW(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .key_busy(key_busy), .key_err(key_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_round(out_round), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    int           r;
    logic         l;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] m_key [0:NR];
  int           m_pos;     // position of the next beat within its block
  logic         m_err;
  int           n_checks = 0;
  int           n_errors = 0;

  // FIPS-197 Appendix A.1 expanded key for 2b7e151628aed2a6abf7158809cf4f3c
  logic [127:0] fips_keys [0:NR] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor/scoreboard: samples mid-cycle what the coming rising edge will do.
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ready;
    logic busy_now;
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      m_pos = 0;
      m_err = 1'b0;
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_out_round", {124'd0, out_round}, 128'd0);
      chk("rst_key_busy", {127'd0, key_busy}, 128'd0);
      chk("rst_key_err", {127'd0, key_err}, 128'd0);
    end else begin
      exp_valid = (sb_q.size() != 0);
      exp_ready = !exp_valid || out_ready;
      busy_now  = (m_pos != 0);
      chk("out_valid", {127'd0, out_valid}, {127'd0, exp_valid});
      chk("in_ready", {127'd0, in_ready}, {127'd0, exp_ready});
      chk("key_busy", {127'd0, key_busy}, {127'd0, busy_now});
      chk("key_err", {127'd0, key_err}, {127'd0, m_err});
      if (exp_valid) begin
        e = sb_q[0];
        chk("out_data", out_data, e.d);
        chk("out_round", {124'd0, out_round}, 128'(e.r));
        chk("out_last", {127'd0, out_last}, {127'd0, e.l});
        if (out_ready) void'(sb_q.pop_front());
      end
      if (in_valid && exp_ready) begin
        e.d = in_data ^ m_key[m_pos];
        e.r = m_pos;
        e.l = (m_pos == NR);
        sb_q.push_back(e);
        m_pos = (m_pos + 1) % (NR + 1);
      end
      if (key_we) begin
        if (busy_now || int'(key_waddr) > NR) m_err = 1'b1;
        else m_key[key_waddr] = key_wdata;
      end
    end
  end

  // All drivers act 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [127:0] d);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic key_write(input logic [3:0] a, input logic [127:0] d);
    key_we    = 1'b1;
    key_waddr = a;
    key_wdata = d;
    tick();
    key_we    = 1'b0;
  endtask

  task automatic finish_block();
    for (int i = 0; i < 2 * (NR + 1) && m_pos != 0; i++) beat(rnd128());
    chk("block_end", 128'(m_pos), 128'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; key_we = 1'b0; key_waddr = '0; key_wdata = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i <= NR; i++) key_write(4'(i), fips_keys[i]);

    // FIPS-197 round 0 vector
    beat(128'h3243f6a8885a308d313198a2e0370734);
    chk("fips_out_data", out_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("fips_out_round", {124'd0, out_round}, 128'd0);
    chk("fips_out_last", {127'd0, out_last}, 128'd0);
    finish_block();

    // Full block streamed back-to-back
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i <= NR; i++) begin
      in_data = rnd128();
      tick();
    end
    in_valid = 1'b0;
    chk("stream_last_round", {124'd0, out_round}, 128'(NR));
    chk("stream_last_flag", {127'd0, out_last}, 128'd1);
    chk("stream_idle_busy", {127'd0, key_busy}, 128'd0);
    tick();

    // Backpressure with a valid input pending
    in_valid = 1'b1; in_data = rnd128(); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      in_data = rnd128();
    end
    chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    finish_block();

    // Key write while busy is dropped
    beat(rnd128());
    key_write(4'd3, rnd128());
    chk("busy_write_err", {127'd0, key_err}, 128'd1);
    finish_block();
    chk("err_sticky", {127'd0, key_err}, 128'd1);

    // Out-of-range index, then valid index while idle
    do_reset();
    key_write(4'd11, rnd128());
    chk("addr11_err", {127'd0, key_err}, 128'd1);
    do_reset();
    key_write(4'd10, rnd128());
    chk("addr10_no_err", {127'd0, key_err}, 128'd0);
    for (int i = 0; i <= NR; i++) beat(rnd128());

    // Same-edge write and accept at round 0 uses the old key
    key_we = 1'b1; key_waddr = 4'd0; key_wdata = rnd128();
    in_valid = 1'b1; in_data = rnd128(); out_ready = 1'b1;
    tick();
    key_we = 1'b0; in_valid = 1'b0;
    finish_block();

    // Reset mid-block
    for (int i = 0; i < 4; i++) beat(rnd128());
    in_valid = 1'b1; in_data = rnd128(); out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    beat(rnd128());
    chk("post_rst_round", {124'd0, out_round}, 128'd0);
    finish_block();

    // Randomised traffic with occasional key writes
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rnd128();
      out_ready = ($urandom_range(0, 3) != 0);
      key_we    = ($urandom_range(0, 7) == 0);
      key_waddr = 4'($urandom_range(0, 15));
      key_wdata = rnd128();
      tick();
    end
    in_valid = 1'b0; key_we = 1'b0; out_ready = 1'b1;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
